// File: rtl/channel_service_scheduler_pkg.sv
// Shared types and constants for the channel service scheduler.
package sched_pkg;

  localparam int N_CHAN_DEF     = 8;
  localparam int DATA_W_DEF     = 8;
  localparam int PRIO_W_DEF     = 3;
  localparam int RD_LATENCY_DEF = 2;
  localparam int PRI_LAG_DEF    = 3;
  localparam int BURST_MAX_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT,
    PRESENT,
    GAP
  } sched_state_e;

  localparam logic [2:0] CHAN_EMPTY = 3'd0;
  localparam logic [2:0] CHAN_FULL  = 3'd6;
  localparam logic [2:0] CHAN_RSVD  = 3'd7;

  localparam int             AGE_W   = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

endpackage

// File: rtl/channel_service_scheduler_if.sv
// Channel-head bank and output stream seen by the scheduler; master = scheduler side.
interface channel_service_scheduler_if #(
  parameter int N_CHAN = 8,
  parameter int DATA_W = 8,
  parameter int PRIO_W = 3
);
  localparam int CHW = $clog2(N_CHAN);

  logic                       sched_enable;
  logic [N_CHAN-1:0]          chan_mask;
  logic [N_CHAN*PRIO_W-1:0]   chan_priority;
  logic [N_CHAN*DATA_W-1:0]   chan_data;
  logic [N_CHAN-1:0]          chan_rd_commit;
  logic                       out_valid;
  logic [DATA_W-1:0]          out_data;
  logic [CHW-1:0]             out_chan;
  logic                       out_ready;
  logic                       busy;

  modport master (
    input  sched_enable, chan_mask, chan_priority, chan_data, out_ready,
    output chan_rd_commit, out_valid, out_data, out_chan, busy
  );

  modport slave (
    output sched_enable, chan_mask, chan_priority, chan_data, out_ready,
    input  chan_rd_commit, out_valid, out_data, out_chan, busy
  );

endinterface

// File: rtl/channel_service_scheduler_rr_prio_picker.sv
// Combinational pick: highest priority among eligible channels, ties to the first index at/after rr_ptr.
// A saturated age outranks any priority, so aged channels win (still RR among themselves).
module rr_prio_picker
  import sched_pkg::*;
#(
  parameter int N_CHAN = 8,
  parameter int PRIO_W = 3,
  parameter int CHW    = $clog2(N_CHAN)
) (
  input  logic [N_CHAN*PRIO_W-1:0] prio,
  input  logic [N_CHAN-1:0]        elig,
  input  logic [CHW-1:0]           rr_ptr,
  input  logic [N_CHAN*AGE_W-1:0]  ages,
  output logic                     grant_vld,
  output logic [CHW-1:0]           grant_idx
);

  always_comb begin
    logic [PRIO_W:0] best_key;
    logic [PRIO_W:0] key;
    logic [CHW-1:0]  idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    best_key  = '0;
    key       = '0;
    idx       = '0;
    // Strict '>' while walking from rr_ptr keeps the earliest tied index.
    for (int k = 0; k < N_CHAN; k++) begin
      idx = CHW'((int'(rr_ptr) + k) % N_CHAN);
      key = {(ages[idx*AGE_W +: AGE_W] == AGE_MAX), prio[idx*PRIO_W +: PRIO_W]};
      if (elig[idx] && (!grant_vld || key > best_key)) begin
        grant_vld = 1'b1;
        grant_idx = idx;
        best_key  = key;
      end
    end
  end

endmodule

// File: rtl/channel_service_scheduler.sv
// Drains channel-head FIFOs onto one valid/ready stream, highest fill priority first, in bursts per grant.
// Optional feature macro SCHED_AGING_EN: per-channel ages bound starvation of low-priority channels.
module channel_service_scheduler
  import sched_pkg::*;
#(
  parameter int N_CHAN     = N_CHAN_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PRIO_W     = PRIO_W_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int PRI_LAG    = PRI_LAG_DEF,
  parameter int BURST_MAX  = BURST_MAX_DEF
) (
  input logic clk,
  input logic rst_n,
  channel_service_scheduler_if.master sif
);

  localparam int CHW   = $clog2(N_CHAN);
  localparam int BCW   = $clog2(BURST_MAX + 1);
  localparam int GAP_W = 4;
  localparam logic [GAP_W-1:0] CAP_AT  = GAP_W'(RD_LATENCY - 1);
  localparam logic [GAP_W-1:0] LAG_AT  = GAP_W'(PRI_LAG - 1);
  localparam logic [BCW-1:0]   BMAX    = BCW'(BURST_MAX);
  localparam logic [CHW-1:0]   LAST_CH = CHW'(N_CHAN - 1);

  sched_state_e      state_q, state_d;
  logic [CHW-1:0]    rr_q, rr_d;
  logic [CHW-1:0]    g_q, g_d;
  logic [BCW-1:0]    burst_q, burst_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CHW-1:0]    chan_q, chan_d;

  logic [N_CHAN-1:0]       elig;
  logic [N_CHAN*AGE_W-1:0] ages;
  logic                    grant_vld;
  logic [CHW-1:0]          grant_idx;
  logic                    idle_grant, cont_ok, gap_ok;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      elig[i] = sif.chan_mask[i]
             && (sif.chan_priority[i*PRIO_W +: PRIO_W] != PRIO_W'(CHAN_EMPTY))
             && (sif.chan_priority[i*PRIO_W +: PRIO_W] != PRIO_W'(CHAN_RSVD));
    end
  end

  rr_prio_picker #(.N_CHAN(N_CHAN), .PRIO_W(PRIO_W), .CHW(CHW)) u_picker (
    .prio      (sif.chan_priority),
    .elig      (elig),
    .rr_ptr    (rr_q),
    .ages      (ages),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  assign idle_grant = (state_q == IDLE) && sif.sched_enable && grant_vld;
  assign cont_ok    = sif.sched_enable && elig[g_q] && (burst_q < BMAX);
  // gap_q counts cycles since GRANT; at LAG_AT the next cycle may commit again.
  assign gap_ok     = (gap_q >= LAG_AT);

`ifdef SCHED_AGING_EN
  logic [N_CHAN*AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < N_CHAN; i++) begin
      if (!elig[i]) begin
        age_d[i*AGE_W +: AGE_W] = '0;
      end else if (idle_grant) begin
        if (grant_idx == CHW'(i))
          age_d[i*AGE_W +: AGE_W] = '0;
        else if (age_q[i*AGE_W +: AGE_W] != AGE_MAX)
          age_d[i*AGE_W +: AGE_W] = age_q[i*AGE_W +: AGE_W] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= '0;
    else        age_q <= age_d;
  end

  assign ages = age_q;
`else
  assign ages = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      burst_q <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    burst_d = burst_q;
    gap_d   = (gap_q == '1) ? gap_q : gap_q + 1'b1;
    data_d  = data_q;
    chan_d  = chan_q;
    unique case (state_q)
      IDLE: begin
        if (idle_grant) begin
          state_d = GRANT;
          g_d     = grant_idx;
          rr_d    = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end
      end
      GRANT: begin
        burst_d = burst_q + 1'b1;
        gap_d   = GAP_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (gap_q >= CAP_AT) begin
          data_d  = sif.chan_data[g_q*DATA_W +: DATA_W];
          chan_d  = g_q;
          state_d = PRESENT;
        end
      end
      // Accept can go straight to the next commit when the settle time has already elapsed.
      PRESENT, GAP: begin
        if (state_q == GAP || sif.out_ready) begin
          if (!gap_ok) begin
            state_d = GAP;
          end else if (cont_ok) begin
            state_d = GRANT;
          end else begin
            state_d = IDLE;
            burst_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sif.chan_rd_commit = '0;
    if (state_q == GRANT) sif.chan_rd_commit[g_q] = 1'b1;
  end

  assign sif.out_valid = (state_q == PRESENT);
  assign sif.out_data  = data_q;
  assign sif.out_chan  = chan_q;
  assign sif.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_channel_service_scheduler.sv
// Directed bench for channel_service_scheduler: channel model returns {chan[2:0], read_count[4:0]} per read.
module tb_channel_service_scheduler;
  import sched_pkg::*;

  localparam int NC = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  channel_service_scheduler_if #(.N_CHAN(NC), .DATA_W(8), .PRIO_W(3)) sif ();

  channel_service_scheduler #(
    .N_CHAN(NC), .DATA_W(8), .PRIO_W(3), .RD_LATENCY(2), .PRI_LAG(3), .BURST_MAX(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int onehot_bad = 0;
  int prio[NC];
  int fill[NC];
  bit use_fill[NC];
  int cnt[NC];
  int cq_ch[$];
  int cq_cyc[$];
  int aq_ch[$];
  int aq_dat[$];
  int aq_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NC; i++) begin
      sif.chan_priority[i*3 +: 3] = 3'(prio[i]);
      sif.chan_data[i*8 +: 8]     = {3'(i), 5'(cnt[i])};
    end
  endtask

  // Observe the current cycle (inputs as the DUT will see them at the next edge), then advance.
  task automatic step();
    if ($countones(sif.chan_rd_commit) > 1) onehot_bad++;
    if (sif.out_valid && sif.out_ready) begin
      aq_ch.push_back(int'(sif.out_chan));
      aq_dat.push_back(int'(sif.out_data));
      aq_cyc.push_back(cyc);
    end
    for (int i = 0; i < NC; i++) begin
      if (sif.chan_rd_commit[i]) begin
        cq_ch.push_back(i);
        cq_cyc.push_back(cyc);
        cnt[i]++;
        if (use_fill[i]) begin
          fill[i]--;
          if (fill[i] <= 0) prio[i] = 0;
        end
      end
    end
    drive_bus();
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NC; i++) begin
      cnt[i] = 0; prio[i] = 0; fill[i] = 0; use_fill[i] = 1'b0;
    end
    cq_ch.delete(); cq_cyc.delete();
    aq_ch.delete(); aq_dat.delete(); aq_cyc.delete();
    drive_bus();
  endtask

  task automatic set_chan(input int ch, input int p, input int f);
    prio[ch] = p; fill[ch] = f; use_fill[ch] = (f > 0);
    drive_bus();
  endtask

  task automatic wait_commits(input int n, input int budget, input string tag);
    int b = 0;
    while (cq_ch.size() < n && b < budget) begin step(); b++; end
    if (cq_ch.size() < n) check_eq({tag, "_commit_timeout"}, cq_ch.size(), n);
  endtask

  task automatic wait_accepts(input int n, input int budget, input string tag);
    int b = 0;
    while (aq_ch.size() < n && b < budget) begin step(); b++; end
    if (aq_ch.size() < n) check_eq({tag, "_accept_timeout"}, aq_ch.size(), n);
  endtask

  initial begin
    sif.sched_enable = 1'b0;
    sif.out_ready    = 1'b1;
    sif.chan_mask    = '1;
    clear_model();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_commit", sif.chan_rd_commit, 0);
    check_eq("rst_valid",  sif.out_valid, 0);
    check_eq("rst_data",   sif.out_data, 0);
    check_eq("rst_chan",   sif.out_chan, 0);
    check_eq("rst_busy",   sif.busy, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // T1: single channel, latency and data
    sif.sched_enable = 1'b1;
    clear_model();
    set_chan(2, 3, 1);
    wait_commits(1, 20, "t1");
    wait_accepts(1, 20, "t1");
    repeat (6) step();
    check_eq("t1_commit_ch", cq_ch[0], 2);
    check_eq("t1_out_chan",  aq_ch[0], 2);
    check_eq("t1_out_data",  aq_dat[0], 32'h41);
    check_eq("t1_latency",   aq_cyc[0] - cq_cyc[0], 2);
    check_eq("t1_n_commits", cq_ch.size(), 1);
    check_eq("t1_idle_busy", sif.busy, 0);

    // T2: higher priority drains first, then the lower one
    begin : t2
      int ec[5];
      int ed[5];
      ec = '{1, 1, 1, 6, 6};
      ed = '{32'h21, 32'h22, 32'h23, 32'hC1, 32'hC2};
      clear_model();
      set_chan(1, 5, 3);
      set_chan(6, 2, 2);
      wait_commits(5, 80, "t2");
      wait_accepts(5, 20, "t2");
      repeat (6) step();
      check_eq("t2_n_commits", cq_ch.size(), 5);
      for (int k = 0; k < 5; k++) begin
        check_eq($sformatf("t2_chan%0d", k), aq_ch[k], ec[k]);
        check_eq($sformatf("t2_data%0d", k), aq_dat[k], ed[k]);
      end
    end

    // T3: round-robin tie-break with RR pointer at 4
    clear_model();
    set_chan(3, 4, 1);
    wait_commits(1, 20, "t3a");
    wait_accepts(1, 20, "t3a");
    repeat (4) step();
    set_chan(0, 4, 1);
    set_chan(3, 4, 1);
    set_chan(5, 4, 1);
    wait_commits(4, 80, "t3");
    wait_accepts(4, 20, "t3");
    repeat (4) step();
    check_eq("t3_first",  cq_ch[1], 5);
    check_eq("t3_second", cq_ch[2], 0);
    check_eq("t3_third",  cq_ch[3], 3);

    // T4: burst limit, commit spacing, then enable dropped mid-burst
    begin : t4
      int bad_sp;
      int acc_at;
      bad_sp = 0;
      clear_model();
      set_chan(4, 6, 0);
      wait_commits(17, 200, "t4");
      sif.sched_enable = 1'b0;
      acc_at = aq_ch.size();
      for (int k = 1; k < 16; k++)
        if (cq_cyc[k] - cq_cyc[k-1] != 3) bad_sp++;
      repeat (10) step();
      check_eq("t4_spacing_bad", bad_sp, 0);
      check_eq("t4_rearb_gap",   cq_cyc[16] - cq_cyc[15], 4);
      check_eq("t4_rearb_chan",  cq_ch[16], 4);
      check_eq("t4_acc_at_17",   acc_at, 16);
      check_eq("t4_commits_end", cq_ch.size(), 17);
      check_eq("t4_accepts_end", aq_ch.size(), 17);
      check_eq("t4_last_data",   aq_dat[16], 32'h91);
    end

    // T5: backpressure in PRESENT
    begin : t5
      int b;
      int hold_bad;
      logic [7:0] d0;
      logic [2:0] c0;
      b = 0;
      hold_bad = 0;
      clear_model();
      sif.out_ready    = 1'b0;
      sif.sched_enable = 1'b1;
      set_chan(2, 6, 0);
      while (!sif.out_valid && b < 20) begin step(); b++; end
      check_eq("t5_valid_seen", sif.out_valid, 1);
      d0 = sif.out_data;
      c0 = sif.out_chan;
      check_eq("t5_data0", d0, 32'h41);
      check_eq("t5_chan0", c0, 2);
      for (int k = 0; k < 10; k++) begin
        step();
        if (!(sif.out_valid && sif.out_data == d0 && sif.out_chan == c0)) hold_bad++;
      end
      check_eq("t5_hold_bad", hold_bad, 0);
      check_eq("t5_no_commit", cq_ch.size(), 1);
      sif.out_ready = 1'b1;
      wait_commits(2, 20, "t5");
      wait_accepts(2, 20, "t5");
      sif.sched_enable = 1'b0;
      check_eq("t5_acc_data0", aq_dat[0], 32'h41);
      check_eq("t5_acc_data1", aq_dat[1], 32'h42);
      repeat (10) step();
    end

    // T6: reset during WAIT, then RR pointer back at 0
    clear_model();
    sif.sched_enable = 1'b1;
    set_chan(5, 6, 0);
    wait_commits(1, 20, "t6");
    check_eq("t6_busy_pre", sif.busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_commit", sif.chan_rd_commit, 0);
    check_eq("t6_rst_valid",  sif.out_valid, 0);
    check_eq("t6_rst_data",   sif.out_data, 0);
    check_eq("t6_rst_chan",   sif.out_chan, 0);
    check_eq("t6_rst_busy",   sif.busy, 0);
    @(negedge clk);
    clear_model();
    set_chan(1, 3, 1);
    set_chan(6, 3, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_commits(2, 40, "t6");
    repeat (6) step();
    check_eq("t6_rr_first",  cq_ch[0], 1);
    check_eq("t6_rr_second", cq_ch[1], 6);

    // Aging: ch7 prio 1 against a permanently full ch0
    begin : t7
      int b;
      int n0;
      int seen7;
      int exp_n0;
      int exp_seen7;
      b = 0; n0 = 0; seen7 = 0;
`ifdef SCHED_AGING_EN
      exp_n0 = 240; exp_seen7 = 1;
`else
      exp_n0 = 260; exp_seen7 = 0;
`endif
      clear_model();
      set_chan(0, 6, 0);
      set_chan(7, 1, 0);
      while (b < 3000 && cq_ch.size() < 260 &&
             !(cq_ch.size() > 0 && cq_ch[cq_ch.size()-1] == 7)) begin
        step(); b++;
      end
      foreach (cq_ch[k]) begin
        if (cq_ch[k] == 7) seen7 = 1;
        else if (seen7 == 0 && cq_ch[k] == 0) n0++;
      end
      check_eq("t7_ch7_served", seen7, exp_seen7);
      check_eq("t7_ch0_before", n0, exp_n0);
      sif.sched_enable = 1'b0;
      repeat (10) step();
    end

    check_eq("onehot_violations", onehot_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
